// File: rtl/cordic_sched_if.sv
// Request/response bundle for the CORDIC scheduler.
// Two requesters share one bus; the response carries the owner id.
interface cordic_sched_if #(
  parameter int W = 20
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_x;
  logic [2*W-1:0] req_y;
  logic [2*W-1:0] req_angle;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W-1:0]   rsp_x;
  logic [W-1:0]   rsp_y;

  modport master (
    output req_valid, req_x, req_y, req_angle, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y
  );

  modport slave (
    input  req_valid, req_x, req_y, req_angle, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y
  );
endinterface

// File: rtl/cordic_sched.sv
// Two-requester round-robin front end for a multi-cycle CORDIC core.
// Optional quadrant folding: define CORDIC_SCHED_QUAD_FOLD_EN.
module cordic_sched #(
  parameter int W       = 20,
  parameter int LATENCY = 10
) (
  input  logic          clk,
  input  logic          rst,
  cordic_sched_if.slave bus,
  output logic [W-1:0]  core_x_in,
  output logic [W-1:0]  core_y_in,
  output logic [W-1:0]  core_angle_in,
  input  logic [W-1:0]  core_x_out,
  input  logic [W-1:0]  core_y_out,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ptr;
  logic [1:0]    grant;
  logic          wid;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [W-1:0]  rsp_x_q;
  logic [W-1:0]  rsp_y_q;
  logic [W-1:0]  sel_x;
  logic [W-1:0]  sel_y;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  fx;
  logic [W-1:0]  fy;
  logic [W-1:0]  fa;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (bus.req_valid == 2'b11): grant = ptr ? 2'b10 : 2'b01;
      (bus.req_valid == 2'b01): grant = 2'b01;
      (bus.req_valid == 2'b10): grant = 2'b10;
      default:                  grant = 2'b00;
    endcase
  end

  assign wid = grant[1];

  // Gated by rst so no handshake can complete on a reset edge.
  assign bus.req_ready =
    (state == IDLE && !rst) ? grant : 2'b00;

  assign sel_x = wid ? bus.req_x[2*W-1:W]
                     : bus.req_x[W-1:0];
  assign sel_y = wid ? bus.req_y[2*W-1:W]
                     : bus.req_y[W-1:0];
  assign sel_a = wid ? bus.req_angle[2*W-1:W]
                     : bus.req_angle[W-1:0];

`ifdef CORDIC_SCHED_QUAD_FOLD_EN
  localparam logic signed [W:0] Q90 =
    (W+1)'(90 << (W - 8));
  localparam logic signed [W:0] Q180 =
    (W+1)'(180 << (W - 8));

  logic signed [W:0] a_ext;

  // Rotating by a-180 and negating the vector equals rotating by a.
  always_comb begin
    a_ext = {sel_a[W-1], sel_a};
    fx    = sel_x;
    fy    = sel_y;
    fa    = sel_a;
    if (a_ext > Q90) begin
      fa = W'(a_ext - Q180);
      fx = -sel_x;
      fy = -sel_y;
    end else if (a_ext < -Q90) begin
      fa = W'(a_ext + Q180);
      fx = -sel_x;
      fy = -sel_y;
    end
  end
`else
  assign fx = sel_x;
  assign fy = sel_y;
  assign fa = sel_a;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      ptr           <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_x_q       <= '0;
      rsp_y_q       <= '0;
      core_x_in     <= '0;
      core_y_in     <= '0;
      core_angle_in <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            core_x_in     <= fx;
            core_y_in     <= fy;
            core_angle_in <= fa;
            rsp_id_q      <= wid;
            ptr           <= ~wid;
            cnt           <= CNT_LOAD;
            state         <= RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            rsp_x_q     <= core_x_out;
            rsp_y_q     <= core_y_out;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_x     = rsp_x_q;
  assign bus.rsp_y     = rsp_y_q;

endmodule
